// File: rtl/mem_bus_arbiter.sv
// Two-client (icache/dcache) arbiter onto a single burst memory bus: one address beat, then 8 data beats.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise client 0 has fixed priority.
module mem_bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    c_reqcyc,
    input  logic [2*BUS_DATA_WIDTH-1:0]   c_req,
    input  logic [2*BUS_TAG_WIDTH-1:0]    c_reqtag,
    output logic [1:0]                    c_reqack,
    output logic [1:0]                    c_respcyc,
    input  logic [1:0]                    c_respack,
    output logic [BUS_DATA_WIDTH-1:0]     c_resp,
    output logic [BUS_TAG_WIDTH-1:0]      c_resptag,
    output logic                          m_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]     m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]      m_bus_reqtag,
    input  logic                          m_bus_reqack,
    input  logic                          m_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]     m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]      m_bus_resptag,
    output logic                          m_bus_respack,
    output logic [1:0]                    gnt
);

    localparam int unsigned RdBit    = 12;
    localparam logic [3:0]  NumBeats = 4'd8;

    typedef enum logic [1:0] {StIdle, StReq, StWdata, StRdata} state_e;

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic [1:0] winner;
`ifdef ARB_ROUND_ROBIN_EN
    logic       last_q, last_d;
`endif

    logic                      owner;
    logic                      own_reqcyc;
    logic                      own_respack;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_tag;
    logic                      fwd_req;
    logic                      fwd_rd;

    assign owner       = gnt_q[1];
    assign own_reqcyc  = c_reqcyc[owner];
    assign own_respack = c_respack[owner];
    assign own_req     = owner ? c_req[BUS_DATA_WIDTH +: BUS_DATA_WIDTH]
                               : c_req[0 +: BUS_DATA_WIDTH];
    assign own_tag     = owner ? c_reqtag[BUS_TAG_WIDTH +: BUS_TAG_WIDTH]
                               : c_reqtag[0 +: BUS_TAG_WIDTH];

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        // Tie goes to the client that did not win last time.
        if (&c_reqcyc) winner = last_q ? 2'b01 : 2'b10;
        else           winner = c_reqcyc;
`else
        winner = c_reqcyc[0] ? 2'b01 : c_reqcyc;
`endif
    end

    assign cnt_inc = (cnt_q >= NumBeats) ? NumBeats : cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|c_reqcyc) begin
                    gnt_d   = winner;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (m_bus_reqack) begin
                    cnt_d   = '0;
                    state_d = own_tag[RdBit] ? StRdata : StWdata;
                end
            end
            StWdata: begin
                if (m_bus_reqack) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == NumBeats) begin
                        state_d = StIdle;
                        gnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d  = owner;
`endif
                    end
                end
            end
            StRdata: begin
                if (m_bus_respcyc && own_respack) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == NumBeats) begin
                        state_d = StIdle;
                        gnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d  = owner;
`endif
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Bus paths are gated by state so everything reads 0 whenever the FSM sits in reset/idle.
    assign fwd_req = (state_q == StReq) || (state_q == StWdata);
    assign fwd_rd  = (state_q == StRdata);

    assign m_bus_reqcyc  = fwd_req & own_reqcyc;
    assign m_bus_req     = fwd_req ? own_req : '0;
    assign m_bus_reqtag  = fwd_req ? own_tag : '0;
    assign c_reqack      = (fwd_req && m_bus_reqack) ? gnt_q : 2'b00;

    assign c_respcyc     = (fwd_rd && m_bus_respcyc) ? gnt_q : 2'b00;
    assign m_bus_respack = fwd_rd & own_respack;
    assign c_resp        = fwd_rd ? m_bus_resp : '0;
    assign c_resptag     = fwd_rd ? m_bus_resptag : '0;

    assign gnt = gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: scoreboard of expected bus beats, immediate-assertion checks.
module tb_mem_bus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      c_reqcyc;
    logic [2*DW-1:0] c_req;
    logic [2*TW-1:0] c_reqtag;
    logic [1:0]      c_reqack;
    logic [1:0]      c_respcyc;
    logic [1:0]      c_respack;
    logic [DW-1:0]   c_resp;
    logic [TW-1:0]   c_resptag;
    logic            m_bus_reqcyc;
    logic [DW-1:0]   m_bus_req;
    logic [TW-1:0]   m_bus_reqtag;
    logic            m_bus_reqack;
    logic            m_bus_respcyc;
    logic [DW-1:0]   m_bus_resp;
    logic [TW-1:0]   m_bus_resptag;
    logic            m_bus_respack;
    logic [1:0]      gnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] sb[$];

    mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .c_reqcyc     (c_reqcyc),
        .c_req        (c_req),
        .c_reqtag     (c_reqtag),
        .c_reqack     (c_reqack),
        .c_respcyc    (c_respcyc),
        .c_respack    (c_respack),
        .c_resp       (c_resp),
        .c_resptag    (c_resptag),
        .m_bus_reqcyc (m_bus_reqcyc),
        .m_bus_req    (m_bus_req),
        .m_bus_reqtag (m_bus_reqtag),
        .m_bus_reqack (m_bus_reqack),
        .m_bus_respcyc(m_bus_respcyc),
        .m_bus_resp   (m_bus_resp),
        .m_bus_resptag(m_bus_resptag),
        .m_bus_respack(m_bus_respack),
        .gnt          (gnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sense;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int c);
        return (c == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic set_client(input int c, input logic [63:0] v, input logic [12:0] tag);
        c_req[c*DW +: DW]    = v;
        c_reqtag[c*TW +: TW] = tag;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},       64'(gnt),           64'd0);
        chk({tag, "_reqack"},    64'(c_reqack),      64'd0);
        chk({tag, "_respcyc"},   64'(c_respcyc),     64'd0);
        chk({tag, "_resp"},      c_resp,             64'd0);
        chk({tag, "_resptag"},   64'(c_resptag),     64'd0);
        chk({tag, "_m_reqcyc"},  64'(m_bus_reqcyc),  64'd0);
        chk({tag, "_m_req"},     m_bus_req,          64'd0);
        chk({tag, "_m_reqtag"},  64'(m_bus_reqtag),  64'd0);
        chk({tag, "_m_respack"}, 64'(m_bus_respack), 64'd0);
    endtask

    // Address phase; pre = request already presented, hold = keep c_reqcyc after the address ack.
    task automatic req_phase(input int c, input logic [63:0] addr, input logic [12:0] tag,
                             input bit pre, input bit hold);
        logic [63:0] e;
        if (!pre) begin
            tick;
            c_reqcyc[c] = 1'b1;
            set_client(c, addr, tag);
            sense;
            chk("idle_no_fwd", 64'(m_bus_reqcyc), 64'd0);
            chk("idle_gnt", 64'(gnt), 64'd0);
        end
        tick;
        m_bus_reqack = 1'b1;
        sb.push_back(addr);
        sense;
        chk("req_gnt", 64'(gnt), 64'(oh(c)));
        chk("req_m_reqcyc", 64'(m_bus_reqcyc), 64'd1);
        e = sb.pop_front();
        chk("req_addr", m_bus_req, e);
        chk("req_tag", 64'(m_bus_reqtag), 64'(tag));
        chk("req_ack", 64'(c_reqack), 64'(oh(c)));
        tick;
        m_bus_reqack = 1'b0;
        if (!hold) c_reqcyc = 2'b00;
    endtask

    task automatic read_beats(input int c, input logic [63:0] base, input logic [12:0] tag,
                              input int stall_beat, input int stall_len, input int late_beat,
                              input int rst_beat);
        logic [63:0] d;
        logic [63:0] e;
        for (int b = 0; b < 8; b++) begin
            d = base + 64'(b);
            if (b == late_beat) begin
                c_reqcyc[1-c] = 1'b1;
                set_client(1 - c, 64'h3000, 13'h1000);
            end
            if (b == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    m_bus_respcyc = 1'b1;
                    m_bus_resp    = d;
                    m_bus_resptag = tag;
                    c_respack[c]  = 1'b0;
                    sense;
                    chk("stall_respack", 64'(m_bus_respack), 64'd0);
                    chk("stall_respcyc", 64'(c_respcyc), 64'(oh(c)));
                    tick;
                end
            end
            m_bus_respcyc = 1'b1;
            m_bus_resp    = d;
            m_bus_resptag = tag;
            c_respack[c]  = 1'b1;
            if (b == rst_beat) begin
                #2 reset = 1'b0;
                #1 chk_all_zero("rst_inflight");
                return;
            end
            sb.push_back(d);
            sense;
            chk("rd_respcyc", 64'(c_respcyc), 64'(oh(c)));
            e = sb.pop_front();
            chk("rd_data", c_resp, e);
            chk("rd_tag", 64'(c_resptag), 64'(tag));
            chk("rd_respack", 64'(m_bus_respack), 64'd1);
            chk("rd_no_reqack", 64'(c_reqack), 64'd0);
            tick;
        end
        m_bus_respcyc = 1'b0;
        c_respack     = 2'b00;
        sense;
        chk("rd_done_gnt", 64'(gnt), 64'd0);
        chk("rd_done_respcyc", 64'(c_respcyc), 64'd0);
    endtask

    task automatic write_txn(input int c, input logic [63:0] addr, input logic [12:0] tag,
                             input logic [63:0] base);
        logic [63:0] d;
        logic [63:0] e;
        req_phase(c, addr, tag, 1'b0, 1'b1);
        for (int b = 0; b < 8; b++) begin
            d = base + 64'(b);
            set_client(c, d, tag);
            m_bus_reqack = 1'b1;
            sb.push_back(d);
            sense;
            e = sb.pop_front();
            chk("wr_data", m_bus_req, e);
            chk("wr_ack", 64'(c_reqack), 64'(oh(c)));
            chk("wr_reqcyc", 64'(m_bus_reqcyc), 64'd1);
            chk("wr_gnt", 64'(gnt), 64'(oh(c)));
            tick;
        end
        m_bus_reqack = 1'b0;
        c_reqcyc     = 2'b00;
        sense;
        chk("wr_done_gnt", 64'(gnt), 64'd0);
    endtask

    initial begin
        int w;
        reset         = 1'b0;
        c_reqcyc      = '0;
        c_req         = '0;
        c_reqtag      = '0;
        c_respack     = '0;
        m_bus_reqack  = 1'b0;
        m_bus_respcyc = 1'b0;
        m_bus_resp    = '0;
        m_bus_resptag = '0;

        sense;
        chk_all_zero("reset");
        tick;
        reset = 1'b1;

        // Client 0 read
        req_phase(0, 64'h1000, 13'h1000, 1'b0, 1'b0);
        read_beats(0, 64'h11, 13'h1000, -1, 0, -1, -1);

        // Client 1 write
        write_txn(1, 64'h2040, 13'h0005, 64'hA0);

        // Owner stalls respack at beat 2
        req_phase(0, 64'h4000, 13'h1000, 1'b0, 1'b0);
        read_beats(0, 64'h21, 13'h1000, 2, 3, -1, -1);

        // Client 1 arrives mid-read and is served after one idle cycle
        req_phase(0, 64'h5000, 13'h1000, 1'b0, 1'b0);
        read_beats(0, 64'h31, 13'h1000, -1, 0, 3, -1);
        req_phase(1, 64'h3000, 13'h1000, 1'b1, 1'b0);
        read_beats(1, 64'h41, 13'h1000, -1, 0, -1, -1);

        // Simultaneous requests, four rounds
        tick;
        set_client(0, 64'h6000, 13'h1000);
        set_client(1, 64'h7000, 13'h1000);
        c_reqcyc = 2'b11;
        sense;
        chk("tie_idle_gnt", 64'(gnt), 64'd0);
        for (int r = 0; r < 4; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = r % 2;
`else
            w = 0;
`endif
            req_phase(w, (w == 1) ? 64'h7000 : 64'h6000, 13'h1000, 1'b1, r != 3);
            read_beats(w, 64'h50 + 64'(16 * r), 13'h1000, -1, 0, -1, -1);
        end

        // Reset during read beat 5, then client 1 read right after release
        req_phase(0, 64'h8000, 13'h1000, 1'b0, 1'b0);
        read_beats(0, 64'h61, 13'h1000, -1, 0, -1, 5);
        m_bus_respcyc = 1'b0;
        c_respack     = 2'b00;
        c_reqcyc[1]   = 1'b1;
        set_client(1, 64'h9000, 13'h1000);
        sense;
        chk("in_reset_gnt", 64'(gnt), 64'd0);
        chk("in_reset_m_reqcyc", 64'(m_bus_reqcyc), 64'd0);
        tick;
        reset = 1'b1;
        sense;
        chk("post_rst_idle_gnt", 64'(gnt), 64'd0);
        req_phase(1, 64'h9000, 13'h1000, 1'b1, 1'b0);
        read_beats(1, 64'h71, 13'h1000, -1, 0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
